// File: rtl/lsf_lut_rom_reader_pkg.sv
// Shared LSF constants and LUT request/beat types for the LUT ROM reader path.
package lsf_lut_rom_reader_pkg;

  localparam int LUT_ADDR_WIDTH         = 12;
  localparam int ROM_INDEX_WIDTH        = 3;
  localparam int NUM_ROMS               = 6;
  localparam int ROM_DATA_WIDTH         = 18;
  localparam int BURST_LEN              = 4;
  localparam int ROM_LAT                = 2;
  localparam int SF2PTCALC_SEGANGLE_LEN = 11;
  localparam int BEAT_W                 = $clog2(BURST_LEN) + 1;

  typedef struct packed {
    logic [LUT_ADDR_WIDTH-1:0]         addr;
    logic [ROM_INDEX_WIDTH-1:0]        rom;
    logic [SF2PTCALC_SEGANGLE_LEN-1:0] angle;
  } lsf_lut_req_t;

  typedef struct packed {
    logic [ROM_DATA_WIDTH-1:0]         data;
    logic [BEAT_W-1:0]                 beat;
    logic                              last;
    logic [SF2PTCALC_SEGANGLE_LEN-1:0] angle;
  } lsf_lut_beat_t;

endpackage

// File: rtl/lsf_rd_valid_pipe.sv
// Fixed-depth valid/tag shift register that tracks ROM reads until their data returns.
module lsf_rd_valid_pipe
  import lsf_lut_rom_reader_pkg::*;
#(
  parameter int DEPTH = ROM_LAT,
  parameter int TAG_W = BEAT_W + 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_vld,
  output logic [TAG_W-1:0] o_tag
);

  logic [DEPTH-1:0] r_vld;
  logic [TAG_W-1:0] r_tag [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_tag[0] <= i_vld ? i_tag : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_tag = r_tag[DEPTH-1];

endmodule

// File: rtl/lsf_lut_rom_reader.sv
// Reads a BURST_LEN-word burst from the selected LUT ROM per request and streams it
// downstream with beat index, last flag and the captured segment angle.
module lsf_lut_rom_reader
  import lsf_lut_rom_reader_pkg::*;
#(
  parameter int P_LUT_ADDR_WIDTH  = LUT_ADDR_WIDTH,
  parameter int P_ROM_INDEX_WIDTH = ROM_INDEX_WIDTH,
  parameter int P_NUM_ROMS        = NUM_ROMS,
  parameter int P_ROM_DATA_WIDTH  = ROM_DATA_WIDTH,
  parameter int P_BURST_LEN       = BURST_LEN,
  parameter int P_ROM_LAT         = ROM_LAT,
  parameter int P_ANGLE_W         = SF2PTCALC_SEGANGLE_LEN,
  localparam int P_BEAT_W         = $clog2(P_BURST_LEN) + 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in_vld,
  output logic                         o_in_rdy,
  input  logic [P_LUT_ADDR_WIDTH-1:0]  i_lut_start_addr,
  input  logic [P_ROM_INDEX_WIDTH-1:0] i_rom_index,
  input  logic [P_ANGLE_W-1:0]         i_slcvec_angle_mrad,
  output logic                         o_rom_rd_en,
  output logic [P_ROM_INDEX_WIDTH-1:0] o_rom_sel,
  output logic [P_LUT_ADDR_WIDTH-1:0]  o_rom_addr,
  input  logic [P_ROM_DATA_WIDTH-1:0]  i_rom_rd_data,
  output logic                         o_out_vld,
  output logic [P_ROM_DATA_WIDTH-1:0]  o_out_data,
  output logic [P_BEAT_W-1:0]          o_out_beat,
  output logic                         o_out_last,
  output logic [P_ANGLE_W-1:0]         o_out_angle,
  output logic                         o_err_bad_rom,
  output logic [7:0]                   o_drop_cnt
);

  // state | meaning
  // IDLE  | ready for a request
  // READ  | issuing one ROM read per cycle
  // DRAIN | waiting ROM_LAT cycles for the last read to return
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int DRAIN_W = $clog2(P_ROM_LAT) + 1;
  localparam logic [P_BEAT_W-1:0]        LAST_BEAT  = P_BEAT_W'(P_BURST_LEN - 1);
  localparam logic [DRAIN_W-1:0]         DRAIN_LOAD = DRAIN_W'(P_ROM_LAT - 1);
  localparam logic [P_ROM_INDEX_WIDTH:0] ROM_LIMIT  = (P_ROM_INDEX_WIDTH+1)'(P_NUM_ROMS);

  logic [1:0]                   r_state;
  logic [P_LUT_ADDR_WIDTH-1:0]  r_addr;
  logic [P_ROM_INDEX_WIDTH-1:0] r_rom;
  logic [P_ANGLE_W-1:0]         r_angle;
  logic [P_BEAT_W-1:0]          r_beat;
  logic [DRAIN_W-1:0]           r_drain;
  logic                         r_err;
  logic [7:0]                   r_drop;

  logic                w_in_rdy;
  logic                w_accept;
  logic                w_bad;
  logic                w_rd_en;
  logic                w_last_issue;
  logic                w_pipe_vld;
  logic [P_BEAT_W:0]   w_pipe_tag;

  assign w_in_rdy     = (r_state == ST_IDLE);
  assign w_accept     = i_in_vld & w_in_rdy;
  assign w_bad        = ({1'b0, i_rom_index} >= ROM_LIMIT);
  assign w_rd_en      = (r_state == ST_READ);
  assign w_last_issue = w_rd_en & (r_beat == LAST_BEAT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rom   <= '0;
      r_angle <= '0;
      r_beat  <= '0;
      r_drain <= '0;
      r_err   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_err <= w_accept & w_bad;
      if (i_in_vld && !w_in_rdy && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      case (r_state)
        ST_IDLE: begin
          // A bad index is reported but leaves the captured read context untouched.
          if (w_accept && !w_bad) begin
            r_addr  <= i_lut_start_addr;
            r_rom   <= i_rom_index;
            r_angle <= i_slcvec_angle_mrad;
            r_beat  <= '0;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_last_issue) begin
            r_drain <= DRAIN_LOAD;
            r_state <= ST_DRAIN;
          end else begin
            r_beat <= r_beat + 1'b1;
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) r_state <= ST_IDLE;
          else               r_drain <= r_drain - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lsf_rd_valid_pipe #(
    .DEPTH (P_ROM_LAT),
    .TAG_W (P_BEAT_W + 1)
  ) u_rd_valid_pipe (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_vld (w_rd_en),
    .i_tag ({r_beat, w_last_issue}),
    .o_vld (w_pipe_vld),
    .o_tag (w_pipe_tag)
  );

  assign o_in_rdy      = w_in_rdy;
  assign o_rom_rd_en   = w_rd_en;
  assign o_rom_sel     = r_rom;
  assign o_rom_addr    = r_addr;
  assign o_out_vld     = w_pipe_vld;
  assign o_out_data    = w_pipe_vld ? i_rom_rd_data : '0;
  assign o_out_beat    = w_pipe_tag[P_BEAT_W:1];
  assign o_out_last    = w_pipe_tag[0];
  assign o_out_angle   = r_angle;
  assign o_err_bad_rom = r_err;
  assign o_drop_cnt    = r_drop;

endmodule
